// File: rtl/spi_master_ctrl.sv
// Single-clock SPI master feeding the SPI_WRAPPER slave: select cycle, R/W bit,
// 10-bit {cmd, data} frame, and an 8-bit MISO capture for read-data commands.
module spi_master_ctrl #(
    parameter int RD_LATENCY = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        IDLE, SELECT, SEND_RW, SEND_FRAME, WAIT_RD, RECV, END
    } state_t;

    // WAIT_RD is skipped entirely when the slave answers one cycle after the frame.
    localparam bit       SKIP_WAIT = (RD_LATENCY <= 1);
    localparam logic [3:0] WAIT_LAST = 4'((RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0);
    localparam logic [3:0] GAP_LAST  = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t      state_r, state_s;
    logic [9:0]  frame_r, frame_s;
    logic        rd_r, rd_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [7:0]  shift_r, shift_s;
    logic        ss_n_r, ss_n_s;
    logic        mosi_r, mosi_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic [7:0]  rx_data_r, rx_data_s;
    logic        rx_valid_r, rx_valid_s;

    // Next-state and next-output logic; every register has a next value here.
    always_comb begin
        state_s    = state_r;
        frame_s    = frame_r;
        rd_s       = rd_r;
        cnt_s      = cnt_r;
        shift_s    = shift_r;
        ss_n_s     = ss_n_r;
        mosi_s     = mosi_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        rx_data_s  = rx_data_r;
        rx_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    frame_s = {cmd, tx_data};
                    rd_s    = (cmd == 2'b11);
                    cnt_s   = 4'd0;
                    ss_n_s  = 1'b0;
                    mosi_s  = 1'b0;
                    busy_s  = 1'b1;
                    state_s = SELECT;
                end else begin
                    state_s = IDLE;
                end
            end
            SELECT: begin
                mosi_s  = frame_r[9];
                state_s = SEND_RW;
            end
            SEND_RW: begin
                mosi_s  = frame_r[9];
                frame_s = {frame_r[8:0], 1'b0};
                cnt_s   = 4'd1;
                state_s = SEND_FRAME;
            end
            SEND_FRAME: begin
                // cnt_r counts frame bits already driven; the tenth ends the frame.
                if (cnt_r == 4'd10) begin
                    mosi_s = 1'b0;
                    cnt_s  = 4'd0;
                    if (rd_r) begin
                        state_s = SKIP_WAIT ? RECV : WAIT_RD;
                    end else begin
                        ss_n_s  = 1'b1;
                        state_s = END;
                    end
                end else begin
                    mosi_s  = frame_r[9];
                    frame_s = {frame_r[8:0], 1'b0};
                    cnt_s   = cnt_r + 4'd1;
                end
            end
            WAIT_RD: begin
                if (cnt_r == WAIT_LAST) begin
                    cnt_s   = 4'd0;
                    state_s = RECV;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            RECV: begin
                shift_s = {shift_r[6:0], MISO};
                if (cnt_r == 4'd7) begin
                    ss_n_s  = 1'b1;
                    cnt_s   = 4'd0;
                    state_s = END;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            END: begin
                if (cnt_r == GAP_LAST) begin
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    cnt_s   = 4'd0;
                    state_s = IDLE;
                    if (rd_r) begin
                        rx_data_s  = shift_r;
                        rx_valid_s = 1'b1;
                    end else begin
                        rx_data_s = rx_data_r;
                    end
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            default: begin
                ss_n_s  = 1'b1;
                mosi_s  = 1'b0;
                busy_s  = 1'b0;
                cnt_s   = 4'd0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            frame_r    <= 10'd0;
            rd_r       <= 1'b0;
            cnt_r      <= 4'd0;
            shift_r    <= 8'd0;
            ss_n_r     <= 1'b1;
            mosi_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rx_data_r  <= 8'd0;
            rx_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            frame_r    <= frame_s;
            rd_r       <= rd_s;
            cnt_r      <= cnt_s;
            shift_r    <= shift_s;
            ss_n_r     <= ss_n_s;
            mosi_r     <= mosi_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            rx_data_r  <= rx_data_s;
            rx_valid_r <= rx_valid_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign SS_n     = ss_n_r;
    assign MOSI     = mosi_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: cycle-by-cycle framing model plus a
// scoreboard of expected receive results popped on each done pulse.
module tb_spi_master_ctrl;

    localparam int RDL = 2;
    localparam int GAP = 1;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    typedef struct {
        logic       rd;
        logic [7:0] rx;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [7:0] last_rx = 8'h00;

    spi_master_ctrl #(.RD_LATENCY(RDL), .GAP_CYCLES(GAP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cmd      (cmd),
        .tx_data  (tx_data),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Quiet cycles: nothing may start, no pulses, slave deselected.
    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            MISO = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_busy", 8'(busy), 8'd0);
            chk("idle_done", 8'(done), 8'd0);
            chk("idle_rxv", 8'(rx_valid), 8'd0);
            chk("idle_ss", 8'(SS_n), 8'd1);
            chk("idle_rxd", rx_data, last_rx);
        end
    endtask

    // One transaction from the start request to the done cycle (or abort).
    task automatic run_txn(input logic [1:0] c, input logic [7:0] d, input logic [7:0] m,
                           input bit poke, input int abort_k);
        logic [10:0] bits;
        logic        rd;
        int          done_k;
        int          first_s;
        logic        exp_ss;
        logic        exp_mosi;
        exp_t        e;
        bits    = {c[1], c, d};
        rd      = (c == 2'b11);
        first_s = 12 + RDL;
        done_k  = rd ? (19 + RDL + GAP) : (12 + GAP);
        if (abort_k < 0) begin
            e.rd = rd;
            e.rx = m;
            sb.push_back(e);
        end
        for (int k = 0; k <= done_k; k++) begin
            if (k == 0) begin
                start   = 1'b1;
                cmd     = c;
                tx_data = d;
            end else if (poke && k == 4) begin
                start   = 1'b1;
                cmd     = 2'b01;
                tx_data = 8'hFF;
            end else begin
                start   = 1'b0;
                cmd     = 2'($urandom_range(0, 3));
                tx_data = 8'($urandom_range(0, 255));
            end
            if (rd && k >= first_s && k <= first_s + 7) begin
                MISO = m[7 - (k - first_s)];
            end else begin
                MISO = 1'($urandom_range(0, 1));
            end
            rst_n = (k == abort_k) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (k == abort_k) begin
                last_rx = 8'h00;
                chk("abort_ss", 8'(SS_n), 8'd1);
                chk("abort_mosi", 8'(MOSI), 8'd0);
                chk("abort_busy", 8'(busy), 8'd0);
                chk("abort_rxd", rx_data, 8'h00);
                rst_n = 1'b1;
                idle(4);
                return;
            end
            exp_ss   = rd ? (k >= 19 + RDL) : (k >= 12);
            exp_mosi = (k >= 1 && k <= 11) ? bits[11 - k] : 1'b0;
            chk($sformatf("ss_e%0d", k), 8'(SS_n), 8'(exp_ss));
            chk($sformatf("mosi_e%0d", k), 8'(MOSI), 8'(exp_mosi));
            chk($sformatf("busy_e%0d", k), 8'(busy), 8'(k < done_k));
            chk($sformatf("done_e%0d", k), 8'(done), 8'(k == done_k));
            if (k == done_k) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 8'd1, 8'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.rd) last_rx = e.rx;
                    chk("rx_valid", 8'(rx_valid), 8'(e.rd));
                    chk("rx_data", rx_data, last_rx);
                end
            end else begin
                chk($sformatf("rxv_e%0d", k), 8'(rx_valid), 8'd0);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b1;
        cmd     = 2'b00;
        tx_data = 8'h00;
        MISO    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ss", 8'(SS_n), 8'd1);
        chk("rst_mosi", 8'(MOSI), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_rxd", rx_data, 8'h00);
        chk("rst_rxv", 8'(rx_valid), 8'd0);
        rst_n = 1'b1;
        idle(2);

        run_txn(2'b00, 8'hA5, 8'h00, 1'b0, -1);
        idle(2);
        run_txn(2'b11, 8'h00, 8'h3C, 1'b0, -1);
        idle(2);
        run_txn(2'b01, 8'h5A, 8'h00, 1'b1, -1);
        idle(3);
        // Back-to-back: the second start is driven during the done cycle.
        run_txn(2'b10, 8'hC3, 8'h00, 1'b0, -1);
        run_txn(2'b11, 8'h81, 8'h96, 1'b0, -1);
        idle(2);
        run_txn(2'b00, 8'h7E, 8'h00, 1'b0, 6);
        run_txn(2'b00, 8'h7E, 8'h00, 1'b0, -1);
        idle(2);
        run_txn(2'b11, 8'hFF, 8'hA1, 1'b0, -1);
        idle(2);
        chk("sb_drained", 8'(sb.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
